// File: rtl/irq_a12_gen.sv
// irq_a12_gen: scanline-style IRQ counter clocked by filtered PPU A12 rises, with CPU-written latch/reload/enable registers.
module irq_a12_gen #(
  parameter int CNT_W   = 8,
  parameter int FILT_M2 = 3,
  parameter int REV_A   = 0
) (
  input  logic             clk,
  input  logic             map_rst_n,
  input  logic             decode_en,
  input  logic [3:0]       reg_addr,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_m2,
  input  logic             ppu_a12,
  output logic             irq,
  output logic [CNT_W-1:0] cnt_q,
  output logic             clk_evt,
  output logic             reload_pend
);
  logic [1:0]       m2_s, a12_s;
  logic             m2_d, a12_d, irq_en;
  logic [2:0]       low_cnt;
  logic [CNT_W-1:0] latch, latch_nx, cnt_nx;
  logic             m2_fall, accept, wr_c, wr_d, wr_e, wr_f;
  logic             reload, armed, en_nx, irq_set;
  always_comb begin
    m2_fall  = m2_d & ~m2_s[1];
    accept   = a12_s[1] & ~a12_d & (low_cnt == 3'(FILT_M2));
    wr_c     = decode_en && reg_addr == 4'hC;
    wr_d     = decode_en && reg_addr == 4'hD;
    wr_e     = decode_en && reg_addr == 4'hE;
    wr_f     = decode_en && reg_addr == 4'hF;
    latch_nx = wr_c ? cpu_data[CNT_W-1:0] : latch;
    // a same-cycle 4'hD write counts as a pending reload
    reload   = cnt_q == '0 || reload_pend || wr_d;
    cnt_nx   = clk_evt ? (reload ? latch_nx : cnt_q - CNT_W'(1)) : wr_d ? '0 : cnt_q;
    armed    = REV_A == 0 || cnt_q != '0 || reload_pend || wr_d;
    en_nx    = ~wr_e & (wr_f | irq_en);
    irq_set  = clk_evt && cnt_nx == '0 && en_nx && armed;
  end
  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      m2_s        <= '0;
      a12_s       <= '0;
      m2_d        <= 1'b0;
      a12_d       <= 1'b0;
      low_cnt     <= '0;
      clk_evt     <= 1'b0;
      latch       <= '0;
      cnt_q       <= '0;
      reload_pend <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
    end else begin
      m2_s        <= {m2_s[0], cpu_m2};
      a12_s       <= {a12_s[0], ppu_a12};
      m2_d        <= m2_s[1];
      a12_d       <= a12_s[1];
      low_cnt     <= a12_s[1] ? 3'd0 : (m2_fall && low_cnt != 3'(FILT_M2)) ? low_cnt + 3'd1 : low_cnt;
      clk_evt     <= accept;
      latch       <= latch_nx;
      cnt_q       <= cnt_nx;
      reload_pend <= clk_evt ? 1'b0 : wr_d ? 1'b1 : reload_pend;
      irq_en      <= en_nx;
      irq         <= ~wr_e & (irq | irq_set);
    end
  end
endmodule

// File: tb/tb_irq_a12_gen.sv
// tb_irq_a12_gen: directed checks of filtering, counting, IRQ rules, write collisions and async reset.
module tb_irq_a12_gen;
  logic       clk = 1'b0, rst_n = 1'b0, decode_en = 1'b0, cpu_m2 = 1'b0, ppu_a12 = 1'b0;
  logic [3:0] reg_addr = '0;
  logic [7:0] cpu_data = '0;
  logic       irq0, irq1, irq2, evt0, evt1, evt2, rp0, rp1, rp2;
  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;
  int checks = 0, errors = 0;
  int n, at;
  always #5 clk = ~clk;
  irq_a12_gen u0 (.clk(clk), .map_rst_n(rst_n), .decode_en(decode_en), .reg_addr(reg_addr),
    .cpu_data(cpu_data), .cpu_m2(cpu_m2), .ppu_a12(ppu_a12), .irq(irq0), .cnt_q(cnt0),
    .clk_evt(evt0), .reload_pend(rp0));
  irq_a12_gen #(.REV_A(1)) u1 (.clk(clk), .map_rst_n(rst_n), .decode_en(decode_en),
    .reg_addr(reg_addr), .cpu_data(cpu_data), .cpu_m2(cpu_m2), .ppu_a12(ppu_a12), .irq(irq1),
    .cnt_q(cnt1), .clk_evt(evt1), .reload_pend(rp1));
  irq_a12_gen #(.CNT_W(4)) u2 (.clk(clk), .map_rst_n(rst_n), .decode_en(decode_en),
    .reg_addr(reg_addr), .cpu_data(cpu_data), .cpu_m2(cpu_m2), .ppu_a12(ppu_a12), .irq(irq2),
    .cnt_q(cnt2), .clk_evt(evt2), .reload_pend(rp2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    decode_en = 1'b1;
    reg_addr = a;
    cpu_data = d;
    @(negedge clk);
    decode_en = 1'b0;
  endtask
  task automatic m2_fall();
    @(negedge clk);
    cpu_m2 = 1'b1;
    repeat (3) @(negedge clk);
    cpu_m2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  // A12 rise after `falls` M2 falls; optionally issues a write in the clk_evt cycle
  task automatic rise(input int falls, input logic wdo, input logic [3:0] wa, input logic [7:0] wd,
                      output int cnt, output int first);
    cnt = 0;
    first = -1;
    repeat (falls) m2_fall();
    ppu_a12 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      decode_en = 1'b0;
      if (evt0) begin
        cnt++;
        if (first < 0) first = i;
        if (wdo) begin
          decode_en = 1'b1;
          reg_addr = wa;
          cpu_data = wd;
        end
      end
    end
    ppu_a12 = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic rise_ok(input string tag, input logic wdo, input logic [3:0] wa, input logic [7:0] wd);
    int c, f;
    rise(3, wdo, wa, wd, c, f);
    chk({tag, "_nevt"}, c, 1);
    chk({tag, "_lat"}, f, 3);
  endtask
  initial begin
    logic [7:0] exp_cnt [5];
    logic       exp_irq [5];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_irq", irq0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_rp", rp0, 0);
    chk("rst_evt", evt0, 0);
    rst_n = 1'b1;
    // filter: two falls are not enough, three are
    rise(2, 1'b0, 4'h0, 8'h0, n, at);
    chk("filt2_nevt", n, 0);
    chk("filt2_cnt", cnt0, 0);
    rise_ok("filt3", 1'b0, 4'h0, 8'h0);
    chk("filt3_cnt", cnt0, 0);
    chk("filt3_irq", irq0, 0);
    // basic count sequence
    wr(4'hC, 8'd3);
    wr(4'hD, 8'd0);
    chk("wrd_rp", rp0, 1);
    chk("wrd_cnt", cnt0, 0);
    wr(4'hF, 8'd0);
    for (int i = 0; i < 5; i++) begin
      rise_ok("seq", 1'b0, 4'h0, 8'h0);
      chk($sformatf("seq%0d_cnt", i), cnt0, exp_cnt[i]);
      chk($sformatf("seq%0d_irq", i), irq0, exp_irq[i]);
      chk($sformatf("seq%0d_irqA", i), irq1, exp_irq[i]);
      chk($sformatf("seq%0d_cnt4", i), cnt2, exp_cnt[i]);
    end
    chk("seq_rp", rp0, 0);
    // disable write collides with zero-producing event
    rise_ok("dis_a", 1'b0, 4'h0, 8'h0);
    rise_ok("dis_b", 1'b0, 4'h0, 8'h0);
    chk("dis_pre_cnt", cnt0, 1);
    rise_ok("dis_c", 1'b1, 4'hE, 8'h0);
    chk("dis_cnt", cnt0, 0);
    chk("dis_irq", irq0, 0);
    chk("dis_irqA", irq1, 0);
    repeat (4) rise_ok("dis_r", 1'b0, 4'h0, 8'h0);
    chk("dis_r_cnt", cnt0, 0);
    chk("dis_r_irq", irq0, 0);
    chk("dis_r_irqA", irq1, 0);
    wr(4'hF, 8'd0);
    chk("en_irq_hold", irq0, 0);
    // latch 0: rev B re-fires every event, rev A only on reload
    wr(4'hC, 8'd0);
    wr(4'hD, 8'd0);
    rise_ok("z1", 1'b0, 4'h0, 8'h0);
    chk("z1_cnt", cnt0, 0);
    chk("z1_irq", irq0, 1);
    chk("z1_irqA", irq1, 1);
    wr(4'hE, 8'd0);
    chk("z1_clr", irq0, 0);
    chk("z1_clrA", irq1, 0);
    wr(4'hF, 8'd0);
    rise_ok("z2", 1'b0, 4'h0, 8'h0);
    chk("z2_irq", irq0, 1);
    chk("z2_irqA", irq1, 0);
    rise_ok("z3", 1'b0, 4'h0, 8'h0);
    chk("z3_irq", irq0, 1);
    chk("z3_irqA", irq1, 0);
    wr(4'hD, 8'd0);
    rise_ok("z4", 1'b0, 4'h0, 8'h0);
    chk("z4_irqA", irq1, 1);
    // reload collisions
    wr(4'hE, 8'd0);
    wr(4'hF, 8'd0);
    wr(4'hC, 8'd5);
    rise_ok("c1", 1'b0, 4'h0, 8'h0);
    chk("c1_cnt", cnt0, 5);
    chk("c1_irq", irq0, 0);
    rise_ok("c2", 1'b0, 4'h0, 8'h0);
    chk("c2_cnt", cnt0, 4);
    rise_ok("cd", 1'b1, 4'hD, 8'h0);
    chk("cd_cnt", cnt0, 5);
    chk("cd_rp", rp0, 0);
    wr(4'hD, 8'd0);
    rise_ok("cc", 1'b1, 4'hC, 8'd9);
    chk("cc_cnt", cnt0, 9);
    chk("cc_cnt4", cnt2, 9);
    chk("cc_rp", rp0, 0);
    // narrow counter keeps only low bits of latch data
    wr(4'hC, 8'hF7);
    wr(4'hD, 8'd0);
    rise_ok("w4", 1'b0, 4'h0, 8'h0);
    chk("w4_cnt8", cnt0, 8'hF7);
    chk("w4_cnt4", cnt2, 4'h7);
    // async reset mid-filter with cnt 5 and irq set
    wr(4'hC, 8'd1);
    wr(4'hD, 8'd0);
    rise_ok("r1", 1'b0, 4'h0, 8'h0);
    rise_ok("r2", 1'b0, 4'h0, 8'h0);
    chk("r2_irq", irq0, 1);
    wr(4'hC, 8'd5);
    rise_ok("r3", 1'b0, 4'h0, 8'h0);
    chk("r3_cnt", cnt0, 5);
    chk("r3_irq", irq0, 1);
    m2_fall();
    m2_fall();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq", irq0, 0);
    chk("arst_cnt", cnt0, 0);
    chk("arst_rp", rp0, 0);
    chk("arst_evt", evt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rise(1, 1'b0, 4'h0, 8'h0, n, at);
    chk("post_filt_nevt", n, 0);
    rise_ok("post", 1'b0, 4'h0, 8'h0);
    chk("post_cnt", cnt0, 0);
    chk("post_irq", irq0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
